// File: rtl/prng_seq_ctrl.sv
// Control FSM for the 16-bit PRNG datapath: loads seed and count, steps the
// counter, and hands each result z to a valid/ready consumer. Macro PRNG_ITER_CNT_EN enables iter_cnt.
module prng_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] count_in,
    input  logic             eq,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] data_out,
    output logic             lda,
    output logic             ldb,
    output logic             decb,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic [3:0] {
        IDLE, LDA, LDB, CHK, CAP, OUT, DEC, WAIT, FIN
    } state_t;

    state_t state;

    // Strobes are registered alongside the state so each is high exactly
    // while the FSM sits in the matching state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lda       <= 1'b0;
            ldb       <= 1'b0;
            decb      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            lda  <= 1'b0;
            ldb  <= 1'b0;
            decb <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= LDA;
                    lda   <= 1'b1;
                end
                LDA: begin
                    state <= LDB;
                    ldb   <= 1'b1;
                end
                LDB: state <= CHK;
                CHK: if (eq) begin
                    state <= FIN;
                    done  <= 1'b1;
                end else begin
                    state <= CAP;
                end
                CAP: begin
                    result    <= z;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    decb      <= 1'b1;
                    state     <= DEC;
                end
                DEC:  state <= WAIT;
                WAIT: state <= CHK;
                FIN:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Seed and count are only guaranteed stable once busy, so the bus is
    // muxed live from the state rather than captured at start.
    always_comb begin
        data_out = '0;
        if (state == LDA)      data_out = seed_in;
        else if (state == LDB) data_out = count_in;
    end

    assign busy = (state != IDLE);

`ifdef PRNG_ITER_CNT_EN
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (state == IDLE && start)
            cnt_q <= '0;
        else if (state == OUT && out_ready)
            cnt_q <= cnt_q + 1'b1;
    end

    assign iter_cnt = cnt_q;
`else
    assign iter_cnt = '0;
`endif

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Scoreboard bench for prng_seq_ctrl with a behavioural LFSR datapath attached.
module tb_prng_seq_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] seed_in, count_in;
    logic         eq;
    logic [W-1:0] z, data_out, result, iter_cnt;
    logic         lda, ldb, decb, out_valid, out_ready, busy, done;

    int tests = 0;
    int fails = 0;

    prng_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .count_in(count_in),
        .eq(eq), .z(z), .data_out(data_out), .lda(lda), .ldb(ldb), .decb(decb),
        .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lfsr(input logic [W-1:0] a);
        return {a[14:0], a[15] ^ a[13] ^ a[12] ^ a[10]};
    endfunction

    // datapath: A holds the PRNG state, B the remaining count
    logic [W-1:0] dp_a, dp_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a <= '0;
            dp_b <= '0;
        end else begin
            if (lda)       dp_a <= data_out;
            else if (decb) dp_a <= lfsr(dp_a);
            if (ldb)       dp_b <= data_out;
            else if (decb) dp_b <= dp_b - 1'b1;
        end
    end
    assign eq = (dp_b == '0);
    assign z  = dp_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] sb_q[$];
    int n_lda = 0, n_ldb = 0, n_decb = 0, n_done = 0, n_hs = 0, n_overlap = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (lda)  n_lda++;
            if (ldb)  n_ldb++;
            if (decb) n_decb++;
            if (done) n_done++;
            if (done && out_valid) n_overlap++;
            if (out_valid && out_ready) begin
                n_hs++;
                if (sb_q.size() == 0) chk("unexpected_result", 32'(result), 32'hdead);
                else chk("result", 32'(result), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic run(input logic [W-1:0] seed, input logic [W-1:0] cnt,
                       input int stall, input bit repulse);
        int a0, b0, d0, f0, h0, o0;
        int cyc, t_done, t_valid, left, bad;
        logic [W-1:0] a, held;
        a = seed;
        for (int i = 0; i < int'(cnt); i++) begin
            sb_q.push_back(a);
            a = lfsr(a);
        end
        a0 = n_lda; b0 = n_ldb; d0 = n_decb; f0 = n_done; h0 = n_hs; o0 = n_overlap;
        seed_in = seed; count_in = cnt;
        out_ready = (stall == 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1; t_done = -1; t_valid = -1; left = stall; bad = 0; held = '0;
        while (t_done < 0 && cyc < 2000) begin
            if (out_valid && t_valid < 0) t_valid = cyc;
            if (done) t_done = cyc;
            start = (repulse && cyc == 6);
            if (out_valid && left > 0) begin
                if (left == stall) held = result;
                else if (result !== held || decb) bad++;
                left--;
                out_ready = (left == 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (t_done < 0) chk("done_timeout", 1, 0);
        if (cnt == 0) chk("done_latency_cnt0", t_done, 4);
        else if (stall == 0) begin
            chk("first_valid_latency", t_valid, 5);
            chk("done_latency", t_done, 4 + 5 * int'(cnt));
        end
        if (stall > 0) begin
            chk("stall_stable", bad, 0);
            chk("stall_len", left, 0);
        end
        @(negedge clk); #1;
        chk("lda_pulses", n_lda - a0, 1);
        chk("ldb_pulses", n_ldb - b0, 1);
        chk("decb_pulses", n_decb - d0, int'(cnt));
        chk("done_pulses", n_done - f0, 1);
        chk("handshakes", n_hs - h0, int'(cnt));
        chk("sb_empty", sb_q.size(), 0);
        chk("done_valid_overlap", n_overlap - o0, 0);
        chk("busy_after", 32'(busy), 0);
`ifdef PRNG_ITER_CNT_EN
        chk("iter_cnt", 32'(iter_cnt), 32'(cnt));
`else
        chk("iter_cnt_tied", 32'(iter_cnt), 0);
`endif
    endtask

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; seed_in = '0; count_in = '0; out_ready = 1'b0;
        #1;
        chk("reset_outs", {lda, ldb, decb, out_valid, done, busy, result, iter_cnt, data_out}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // abort a run while a result is waiting
        seed_in = 16'h5555; count_in = 16'd2; out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("abort_reached_out", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("abort_outs", {lda, ldb, decb, out_valid, done, busy, result, iter_cnt, data_out}, 0);
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done), 0);
        rst = 1'b0;

        run(16'h1234, 16'd1, 0, 1'b0);
        run(16'hACE1, 16'd3, 0, 1'b0);
        run(16'hBEEF, 16'd0, 0, 1'b0);
        run(16'h0F0F, 16'd2, 10, 1'b0);
        run(16'h8001, 16'd2, 0, 1'b1);
        run(16'h7A5C, 16'd5, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 exp 0");
        $fatal(1, "timeout");
    end
endmodule
